// File: rtl/window_fetcher.sv
// window_fetcher
// Takes one set of ADDR_LENGTH window addresses from the address generator.
// Issues one SRAM read per cycle and packs the returned activations into a
// window register. The completed window goes to the PE array through a
// valid/ready handshake. Only one window is in flight at a time.
//
// Optional build macro: FETCH_BOUND_CHECK_EN. When it is defined, the block
// gains the i_addr_limit port. Any slot whose address is >= i_addr_limit
// still uses its fetch cycle, but no read is issued and the slot is
// zero-padded.
//
// Ports:
//   i_clk, i_nrst       clock, synchronous active-low reset
//   i_reg_clear         synchronous clear back to IDLE (zeroes the window)
//   i_addr_valid/i_addr address set in; o_addr_ready is high in IDLE
//   o_sram_re/o_sram_addr  SRAM read request
//   i_sram_data         read data, valid one cycle after o_sram_re
//   i_addr_limit        (FETCH_BOUND_CHECK_EN only) exclusive address bound
//   o_window/o_valid/i_ready  completed window handshake
//   o_busy              high while fetching or draining
module window_fetcher #(
   parameter int ADDR_WIDTH  = 8,
   parameter int ADDR_LENGTH = 9,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                                     i_clk,
   input  logic                                     i_nrst,
   input  logic                                     i_reg_clear,
   input  logic                                     i_addr_valid,
   input  logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0]   i_addr,
   output logic                                     o_addr_ready,
   output logic                                     o_sram_re,
   output logic [ADDR_WIDTH-1:0]                    o_sram_addr,
   input  logic [DATA_WIDTH-1:0]                    i_sram_data,
`ifdef FETCH_BOUND_CHECK_EN
   input  logic [ADDR_WIDTH-1:0]                    i_addr_limit,
`endif
   output logic [0:ADDR_LENGTH-1][DATA_WIDTH-1:0]   o_window,
   output logic                                     o_valid,
   input  logic                                     i_ready,
   output logic                                     o_busy
);

   localparam int IDX_W = (ADDR_LENGTH > 1) ? $clog2(ADDR_LENGTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ADDR_LENGTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]                                state_q, state_d;
   logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [IDX_W-1:0]                          rd_idx_q, rd_idx_d;
   logic [IDX_W-1:0]                          wr_idx_q, wr_idx_d;
   logic                                      cap_vld_q, cap_vld_d;
   logic                                      cap_zero_q, cap_zero_d;
   logic [0:ADDR_LENGTH-1][DATA_WIDTH-1:0]    win_q, win_d;

   logic [ADDR_WIDTH-1:0] cur_addr;
   logic                  slot_oob;

   assign cur_addr = addr_q[rd_idx_q];

`ifdef FETCH_BOUND_CHECK_EN
   assign slot_oob = (state_q == S_FETCH) && (cur_addr >= i_addr_limit);
`else
   assign slot_oob = 1'b0;
`endif

   assign o_addr_ready = (state_q == S_IDLE);
   assign o_sram_re    = (state_q == S_FETCH) && !slot_oob;
   assign o_sram_addr  = (state_q == S_FETCH) ? cur_addr : '0;
   assign o_valid      = (state_q == S_DONE);
   assign o_busy       = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign o_window     = win_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rd_idx_d   = rd_idx_q;
      wr_idx_d   = wr_idx_q;
      cap_vld_d  = 1'b0;
      cap_zero_d = 1'b0;
      win_d      = win_q;

      // Data for the read issued last cycle arrives now. It lands in the slot
      // recorded alongside that read.
      if (cap_vld_q)
         win_d[wr_idx_q] = cap_zero_q ? '0 : i_sram_data;

      case (state_q)
         S_IDLE: begin
            if (i_addr_valid) begin
               addr_d   = i_addr;
               rd_idx_d = '0;
               state_d  = S_FETCH;
            end
         end
         S_FETCH: begin
            cap_vld_d  = 1'b1;
            wr_idx_d   = rd_idx_q;
            cap_zero_d = slot_oob;
            if (rd_idx_q == LAST_IDX)
               state_d = S_DRAIN;
            else
               rd_idx_d = rd_idx_q + IDX_W'(1);
         end
         S_DRAIN: state_d = S_DONE;   // last word is captured on this edge
         S_DONE: begin
            if (i_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Clear drops any outstanding read and empties the window.
      if (i_reg_clear) begin
         state_d    = S_IDLE;
         rd_idx_d   = '0;
         wr_idx_d   = '0;
         cap_vld_d  = 1'b0;
         cap_zero_d = 1'b0;
         win_d      = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         rd_idx_q   <= '0;
         wr_idx_q   <= '0;
         cap_vld_q  <= 1'b0;
         cap_zero_q <= 1'b0;
         win_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rd_idx_q   <= rd_idx_d;
         wr_idx_q   <= wr_idx_d;
         cap_vld_q  <= cap_vld_d;
         cap_zero_q <= cap_zero_d;
         win_q      <= win_d;
      end
   end

endmodule

// File: tb/tb_window_fetcher.sv
module tb_window_fetcher;
   localparam int AW = 8;
   localparam int AL = 9;
   localparam int DW = 8;

   typedef logic [0:AL-1][AW-1:0] addr_t;
   typedef logic [0:AL-1][DW-1:0] win_t;

   logic          clk = 1'b0;
   logic          nrst, clr, addr_valid, ready;
   addr_t         addr;
   logic          addr_ready, sram_re, valid, busy;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_data;
   win_t          window;
   int            lim = 256;   // exclusive address bound used by the model

   int checks = 0;
   int failures = 0;

   logic [AW-1:0] exp_addr_q[$];
   win_t          exp_win_q[$];

   always #5 clk = ~clk;

   window_fetcher #(.ADDR_WIDTH(AW), .ADDR_LENGTH(AL), .DATA_WIDTH(DW)) dut (
      .i_clk(clk), .i_nrst(nrst), .i_reg_clear(clr),
      .i_addr_valid(addr_valid), .i_addr(addr), .o_addr_ready(addr_ready),
      .o_sram_re(sram_re), .o_sram_addr(sram_addr), .i_sram_data(sram_data),
`ifdef FETCH_BOUND_CHECK_EN
      .i_addr_limit((lim > 255) ? 8'hFF : lim[7:0]),
`endif
      .o_window(window), .o_valid(valid), .i_ready(ready), .o_busy(busy)
   );

   // SRAM model: mem[a] = a + 16, one-cycle read latency. The data is junk
   // when no read was issued, so zero padding is observable.
   always @(posedge clk)
      sram_data <= sram_re ? sram_addr + 8'd16 : 8'hEE;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic win_t model_win(input addr_t a);
      win_t w;
      for (int n = 0; n < AL; n++)
         w[n] = (int'(a[n]) >= lim) ? 8'd0 : a[n] + 8'd16;
      return w;
   endfunction

   // Scoreboard: expectations are pushed when an accept is about to happen.
   // They are popped on each read and on each window handshake.
   always @(negedge clk) begin
      if (nrst && !clr && addr_valid && addr_ready) begin
         for (int n = 0; n < AL; n++)
            if (int'(addr[n]) < lim) exp_addr_q.push_back(addr[n]);
         exp_win_q.push_back(model_win(addr));
      end
      if (nrst && sram_re) begin
         if (exp_addr_q.size() == 0) chk("unexpected_read", {1'b1, sram_addr}, {1'b0, sram_addr});
         else chk("sram_addr", sram_addr, exp_addr_q.pop_front());
      end
      if (nrst && valid && ready) begin
         if (exp_win_q.size() == 0) chk("unexpected_window", 1'b1, 1'b0);
         else chk("window", window, exp_win_q.pop_front());
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Counts edges from now until o_valid. Returns -1 on timeout.
   task automatic wait_valid(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step(); n++;
         if (valid) return;
      end
      n = -1;
   endtask

   task automatic accept(input addr_t a);
      addr = a; addr_valid = 1'b1;
      step();
      addr_valid = 1'b0;
   endtask

   task automatic flush();
      exp_addr_q.delete();
      exp_win_q.delete();
   endtask

   addr_t a_basic, a_b, a_c, a_e, a_f, a_3;
   int    lat;

   initial begin
      a_basic = {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};
      a_b     = {8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28};
      a_c     = {8'd40, 8'd33, 8'd41, 8'd3, 8'd99, 8'd7, 8'd60, 8'd61, 8'd9};
      a_e     = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
      a_f     = {8'd100, 8'd101, 8'd102, 8'd103, 8'd104, 8'd105, 8'd106, 8'd107, 8'd108};
      for (int n = 0; n < AL; n++) a_3[n] = 8'd3;

      nrst = 1'b0; clr = 1'b0; addr_valid = 1'b0; ready = 1'b0; addr = '0;
      repeat (3) step();
      chk("rst_window", window, '0);
      chk("rst_valid", valid, 1'b0);
      chk("rst_re", sram_re, 1'b0);
      chk("rst_sram_addr", sram_addr, '0);
      chk("rst_busy", busy, 1'b0);
      nrst = 1'b1;
      step();
      chk("rst_addr_ready", addr_ready, 1'b1);

      // Basic fetch
      accept(a_basic);
      chk("basic_busy", busy, 1'b1);
      chk("basic_ready_low", addr_ready, 1'b0);
      wait_valid(lat);
      chk("basic_latency", lat, 10);
      chk("basic_window_direct", window, win_t'({8'd16, 8'd17, 8'd18, 8'd21, 8'd22, 8'd23, 8'd26, 8'd27, 8'd28}));
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("basic_valid_drop", valid, 1'b0);
      chk("basic_idle_ready", addr_ready, 1'b1);

      // Backpressure in DONE while a new set is offered
      accept(a_b);
      wait_valid(lat);
      chk("bp_latency", lat, 10);
      addr = a_c; addr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_window_hold", window, model_win(a_b));
         chk("bp_addr_ready", addr_ready, 1'b0);
         chk("bp_no_read", sram_re, 1'b0);
         chk("bp_valid_hold", valid, 1'b1);
      end
      ready = 1'b1;
      step();                       // handshake edge
      ready = 1'b0;
      chk("bp_idle", addr_ready, 1'b1);
      step();                       // new set accepted here
      addr_valid = 1'b0;
      chk("bp_accept_busy", busy, 1'b1);
      wait_valid(lat);
      chk("bp_c_latency", lat, 10);
      ready = 1'b1; step(); ready = 1'b0;

      // Back-to-back with valid held high and ready held high
      addr = a_e; addr_valid = 1'b1; ready = 1'b1;
      step();                       // accept E
      addr = a_f;                   // must not disturb the latched set
      wait_valid(lat);
      chk("b2b_latency_e", lat, 10);
      step();                       // handshake edge
      chk("b2b_idle", addr_ready, 1'b1);
      step();                       // F accepted one cycle later
      addr_valid = 1'b0;
      chk("b2b_accept_f", busy, 1'b1);
      wait_valid(lat);
      chk("b2b_latency_f", lat, 10);
      step();
      ready = 1'b0;

      // Clear mid-fetch at rd_idx = 4
      accept(a_b);
      repeat (4) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      flush();
      chk("clr_idle", addr_ready, 1'b1);
      chk("clr_re", sram_re, 1'b0);
      chk("clr_valid", valid, 1'b0);
      chk("clr_window", window, '0);
      chk("clr_busy", busy, 1'b0);
      step();
      chk("clr_window_after", window, '0);

      // Clear wins over a simultaneous address offer in IDLE
      addr = a_basic; addr_valid = 1'b1; clr = 1'b1;
      step();
      addr_valid = 1'b0; clr = 1'b0;
      chk("clr_vs_valid_busy", busy, 1'b0);
      chk("clr_vs_valid_ready", addr_ready, 1'b1);

      // Reset has priority over clear in DONE
      accept(a_c);
      wait_valid(lat);
      chk("rp_latency", lat, 10);
      nrst = 1'b0; clr = 1'b1;
      step();
      nrst = 1'b1; clr = 1'b0;
      flush();
      chk("rp_window", window, '0);
      chk("rp_valid", valid, 1'b0);
      chk("rp_re", sram_re, 1'b0);
      chk("rp_busy", busy, 1'b0);
      chk("rp_addr_ready", addr_ready, 1'b1);
      accept(a_3);
      wait_valid(lat);
      chk("rp_19_latency", lat, 10);
      chk("rp_19_window", window, win_t'({9{8'd19}}));
      ready = 1'b1; step(); ready = 1'b0;

`ifdef FETCH_BOUND_CHECK_EN
      // Bound check: slots 6..8 pad with zero and issue no read
      lim = 10;
      accept(a_basic);
      for (int i = 0; i < AL; i++) begin
         chk("bc_re", sram_re, (i < 6) ? 1'b1 : 1'b0);
         if (i < AL - 1) step();
      end
      wait_valid(lat);
      chk("bc_latency", lat + 8, 10);
      chk("bc_window", window, win_t'({8'd16, 8'd17, 8'd18, 8'd21, 8'd22, 8'd23, 8'd0, 8'd0, 8'd0}));
      ready = 1'b1; step(); ready = 1'b0;
      lim = 256;
`endif

      step();
      chk("queues_empty", exp_addr_q.size() + exp_win_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/window_fetcher.md
Name: window_fetcher

Overview:
- Sits directly downstream of address_generator in the sequential router.
- Accepts one set of ADDR_LENGTH window addresses, issues one SRAM read per cycle, and packs the returned activations into a window register.
- Presents the completed window to the PE array through a valid/ready handshake.
- Strictly one window in flight; no address or data reuse between windows.

Parameters:
- ADDR_WIDTH, 8, width of each SRAM address
- ADDR_LENGTH, 9, addresses per window (KERNEL_SIZE squared)
- DATA_WIDTH, 8, width of each activation word

Ports:
- i_clk  in  1  clock; all logic on the rising edge
- i_nrst  in  1  synchronous active-low reset
- i_reg_clear  in  1  synchronous clear; returns block to IDLE
- i_addr_valid  in  1  address set valid (address_generator o_valid)
- i_addr  in  [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0]  window addresses (address_generator o_addr)
- o_addr_ready  out  1  block can accept an address set
- o_sram_re  out  1  SRAM read enable
- o_sram_addr  out  ADDR_WIDTH  SRAM read address
- i_sram_data  in  DATA_WIDTH  read data; valid exactly one cycle after o_sram_re
- o_window  out  [0:ADDR_LENGTH-1][DATA_WIDTH-1:0]  fetched window; slot n holds data from i_addr[n]
- o_valid  out  1  o_window complete
- i_ready  in  1  consumer accepts window
- o_busy  out  1  high in FETCH or DRAIN

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_nrst is synchronous and active-low. i_nrst low takes priority over i_reg_clear.
- Reset/clear values: state IDLE; o_window all zero; o_valid 0; o_sram_re 0; o_sram_addr 0; o_busy 0; o_addr_ready 1 on the first cycle after release.
- State machine has four states: IDLE, FETCH, DRAIN, DONE.
- IDLE: o_addr_ready=1. On i_addr_valid & o_addr_ready at an edge, latch all of i_addr into addr_q, set rd_idx=0, go to FETCH. i_addr is not sampled again until the next IDLE.
- FETCH: o_sram_re=1, o_sram_addr=addr_q[rd_idx], rd_idx increments every cycle. Go to DRAIN after the cycle with rd_idx==ADDR_LENGTH-1. The read stream is never stalled.
- Capture: a one-bit valid and a write index are delayed one cycle behind each read. i_sram_data is written to o_window[wr_idx] on the next edge.
- DRAIN: o_sram_re=0; captures the last word, then goes to DONE.
- DONE: o_valid=1 and o_window is held stable. On i_ready go to IDLE; o_valid drops on the following cycle. In DONE, o_addr_ready=0 and i_addr_valid is ignored.
- Latency: o_valid goes high ADDR_LENGTH+1 edges after the accept edge, i.e. 10 for defaults. The earliest next accept is the cycle after the window handshake.
- o_window is not cleared between windows; each slot is overwritten during the next fetch.
- rd_idx and wr_idx are wide enough for ADDR_LENGTH-1 (clog2); they never wrap mid-window.
- Clear or reset mid-FETCH/DRAIN: takes effect at that edge. The outstanding read's data is discarded and o_sram_re is 0 on the next cycle.
- i_reg_clear asserted in IDLE together with i_addr_valid: clear wins and nothing is accepted.

Optional Feature:
- Macro: FETCH_BOUND_CHECK_EN.
- When defined: adds input port i_addr_limit (ADDR_WIDTH). Any slot whose addr_q >= i_addr_limit still consumes its FETCH cycle, so timing is unchanged. That cycle has o_sram_re=0, and the slot is written with zero instead of i_sram_data (zero padding).
- When undefined: the port is absent, every slot is read, and there is no comparator logic.

Test Plan:
- Basic fetch: SRAM model mem[a]=a+16; i_addr={0,1,2,5,6,7,10,11,12} -> o_sram_addr sequence 0,1,2,5,6,7,10,11,12 on 9 consecutive cycles; o_valid 10 edges after accept; o_window={16,17,18,21,22,23,26,27,28}.
- Backpressure: hold i_ready=0 for 5 cycles in DONE while driving i_addr_valid=1 with new addresses -> o_window unchanged, o_addr_ready=0, no reads. Then i_ready=1 -> IDLE, and the new set is accepted on the next cycle.
- Clear mid-fetch: i_reg_clear=1 while rd_idx=4 -> next cycle IDLE, o_sram_re=0, o_valid=0, o_window all zero, o_addr_ready=1.
- Reset priority: i_nrst=0 and i_reg_clear=1 in DONE -> all outputs at reset values. A subsequent fetch of all addresses =3 (mem=19) returns a window of nine 19s.
- Back-to-back: two address sets, second valid held high throughout -> second accepted exactly one cycle after the first window's handshake; both windows correct.
- FETCH_BOUND_CHECK_EN, i_addr_limit=10 with the basic-fetch addresses -> o_sram_re low in cycles 7–9; o_window={16,17,18,21,22,23,0,0,0}; latency still 10.
